sw_fill_ctrl: RTL and testbench

Sequencer for the Smith-Waterman DP score matrix block. It walks the cells row-major for a read/ref pair, fetching the diagonal, up and left neighbours through the matrix's single read/write port. It computes each cell score with linear gap scoring, writes it back, and tracks the maximum score and its position for downstream traceback.

---
 rtl/sw_fill_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sw_fill_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_fill_ctrl.sv
// rtl/sw_fill_ctrl.sv - Smith-Waterman score matrix fill sequencer, linear gap, max tracking
// Optional SW_CYCLE_CNT_EN adds o_cycles, a busy-cycle counter.
module sw_fill_ctrl #(
  parameter int SCORE_W  = 10,
  parameter int LEN_W    = 8,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_read_len,
  input  logic [LEN_W-1:0]   i_ref_len,
  output logic [LEN_W-1:0]   o_read_idx,
  output logic [LEN_W-1:0]   o_ref_idx,
  input  logic [1:0]         i_read_base,
  input  logic [1:0]         i_ref_base,
  output logic               o_mat_start,
  output logic [LEN_W-1:0]   o_mat_i,
  output logic [LEN_W-1:0]   o_mat_j,
  output logic               o_mat_op,
  output logic [SCORE_W-1:0] o_mat_score,
  input  logic [SCORE_W-1:0] i_mat_score,
  output logic               o_busy,
  output logic               o_done,
  output logic [SCORE_W-1:0] o_max_score,
  output logic [LEN_W-1:0]   o_max_i,
  output logic [LEN_W-1:0]   o_max_j
`ifdef SW_CYCLE_CNT_EN
  ,
  output logic [31:0]        o_cycles
`endif
);

  localparam int AW = SCORE_W + 2;
  localparam logic [LEN_W-1:0]     ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0]     MAX_LEN  = LEN_W'(128);
  localparam logic signed [AW-1:0] MATCH_S  = AW'(MATCH);
  localparam logic signed [AW-1:0] MISM_S   = AW'(MISMATCH);
  localparam logic signed [AW-1:0] GAP_S    = AW'(GAP);
  localparam logic signed [AW-1:0] SAT_S    = AW'((1 << SCORE_W) - 1);

  typedef enum logic [2:0] {IDLE, MSTART, RD_D, RD_U, RD_L, CAP_L, WR, DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   n_q, m_q, i_q, j_q, i_nxt, j_nxt;
  logic [LEN_W-1:0]   mat_i_nxt, mat_j_nxt;
  logic               op_nxt, accept, len_ok;
  logic [SCORE_W-1:0] d_q, u_q, l_q;
  logic               match_q;
  logic signed [AW-1:0] d_s, u_s, l_s, h_d, h_u, h_l, h_m;

  assign accept = (state == IDLE) && i_start;
  assign len_ok = (i_read_len != '0) && (i_ref_len != '0) &&
                  (i_read_len <= MAX_LEN) && (i_ref_len <= MAX_LEN);

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (len_ok) begin
            state_nxt = MSTART;
            i_nxt     = ONE;
            j_nxt     = ONE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MSTART: state_nxt = RD_D;
      RD_D:   state_nxt = RD_U;
      RD_U:   state_nxt = RD_L;
      RD_L:   state_nxt = CAP_L;
      CAP_L:  state_nxt = WR;
      WR: begin
        if (i_q == n_q && j_q == m_q) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD_D;
          if (j_q == m_q) begin
            j_nxt = ONE;
            i_nxt = i_q + ONE;
          end else begin
            j_nxt = j_q + ONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Matrix address/op are registered, so they are derived from the coming state.
    mat_i_nxt = '0;
    mat_j_nxt = '0;
    op_nxt    = 1'b0;
    case (state_nxt)
      RD_D: begin mat_i_nxt = i_nxt - ONE; mat_j_nxt = j_nxt - ONE; end
      RD_U: begin mat_i_nxt = i_nxt - ONE; mat_j_nxt = j_nxt;       end
      RD_L: begin mat_i_nxt = i_nxt;       mat_j_nxt = j_nxt - ONE; end
      WR:   begin mat_i_nxt = i_nxt;       mat_j_nxt = j_nxt; op_nxt = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    d_s = $signed({2'b00, d_q});
    u_s = $signed({2'b00, u_q});
    l_s = $signed({2'b00, l_q});
    h_d = match_q ? d_s + MATCH_S : d_s - MISM_S;
    h_u = u_s - GAP_S;
    h_l = l_s - GAP_S;
    h_m = '0;
    if (h_d > h_m) h_m = h_d;
    if (h_u > h_m) h_m = h_u;
    if (h_l > h_m) h_m = h_l;
    if (h_m > SAT_S) h_m = SAT_S;
  end

  assign o_mat_score = (state == WR) ? h_m[SCORE_W-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      n_q         <= '0;
      m_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      d_q         <= '0;
      u_q         <= '0;
      l_q         <= '0;
      match_q     <= 1'b0;
      o_read_idx  <= '0;
      o_ref_idx   <= '0;
      o_mat_start <= 1'b0;
      o_mat_i     <= '0;
      o_mat_j     <= '0;
      o_mat_op    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_max_score <= '0;
      o_max_i     <= '0;
      o_max_j     <= '0;
    end else begin
      state       <= state_nxt;
      i_q         <= i_nxt;
      j_q         <= j_nxt;
      o_mat_i     <= mat_i_nxt;
      o_mat_j     <= mat_j_nxt;
      o_mat_op    <= op_nxt;
      o_mat_start <= (state_nxt == MSTART);
      o_busy      <= (state_nxt != IDLE) && (state_nxt != DONE);
      o_done      <= (state_nxt == DONE);
      if (state_nxt == RD_D) begin
        o_read_idx <= i_nxt - ONE;
        o_ref_idx  <= j_nxt - ONE;
      end
      if (accept) begin
        n_q         <= i_read_len;
        m_q         <= i_ref_len;
        o_max_score <= '0;
        o_max_i     <= '0;
        o_max_j     <= '0;
      end
      // Row 0 / column 0 neighbours are forced to zero; the matrix never holds them.
      case (state)
        RD_U:  d_q <= (i_q == ONE || j_q == ONE) ? '0 : i_mat_score;
        RD_L:  u_q <= (i_q == ONE) ? '0 : i_mat_score;
        CAP_L: begin
          l_q     <= (j_q == ONE) ? '0 : i_mat_score;
          match_q <= (i_read_base == i_ref_base);
        end
        WR: begin
          if (h_m > $signed({2'b00, o_max_score})) begin
            o_max_score <= h_m[SCORE_W-1:0];
            o_max_i     <= i_q;
            o_max_j     <= j_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SW_CYCLE_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    o_cycles <= '0;
    else if (accept) o_cycles <= '0;
    else if (o_busy) o_cycles <= o_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sw_fill_ctrl.sv
// tb/tb_sw_fill_ctrl.sv - self-checking bench for sw_fill_ctrl with a write scoreboard
// Built with SCORE_W=4 so saturation is reachable with short sequences.
module tb_sw_fill_ctrl;
  localparam int SW = 4;
  localparam int LW = 8;
  localparam int MATCH = 2;
  localparam int MISMATCH = 1;
  localparam int GAP = 1;
  localparam int SAT = (1 << SW) - 1;

  typedef struct packed {
    logic [7:0]    i;
    logic [7:0]    j;
    logic [SW-1:0] s;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [LW-1:0] read_len, ref_len, read_idx, ref_idx, mat_i, mat_j, max_i, max_j;
  logic [1:0]    read_base, ref_base;
  logic          mat_start, mat_op, busy, done;
  logic [SW-1:0] mat_score, mat_rd, max_score;
`ifdef SW_CYCLE_CNT_EN
  logic [31:0]   cycles;
`endif

  logic [1:0]    rd_seq [0:255];
  logic [1:0]    rf_seq [0:255];
  logic [SW-1:0] mem    [0:255][0:255];
  bit            seen   [0:255][0:255];

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];

  assign read_base = rd_seq[read_idx];
  assign ref_base  = rf_seq[ref_idx];

  // Matrix model: one-cycle read latency; never-written cells return nonzero junk.
  always @(posedge clk) begin
    if (mat_op) begin
      mem[mat_i][mat_j]  <= mat_score;
      seen[mat_i][mat_j] <= 1'b1;
    end
    mat_rd <= seen[mat_i][mat_j] ? mem[mat_i][mat_j] : SW'(mat_i * 7 + mat_j * 3 + 5);
  end

  sw_fill_ctrl #(.SCORE_W(SW), .LEN_W(LW), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_read_len(read_len), .i_ref_len(ref_len),
    .o_read_idx(read_idx), .o_ref_idx(ref_idx),
    .i_read_base(read_base), .i_ref_base(ref_base),
    .o_mat_start(mat_start), .o_mat_i(mat_i), .o_mat_j(mat_j), .o_mat_op(mat_op),
    .o_mat_score(mat_score), .i_mat_score(mat_rd),
    .o_busy(busy), .o_done(done),
    .o_max_score(max_score), .o_max_i(max_i), .o_max_j(max_j)
`ifdef SW_CYCLE_CNT_EN
    , .o_cycles(cycles)
`endif
  );

  task automatic model_job(input int n, input int m, output int mx, output int mi, output int mj);
    int h [0:128][0:128];
    int s, v;
    wr_t w;
    for (int r = 0; r <= n; r++)
      for (int c = 0; c <= m; c++) h[r][c] = 0;
    mx = 0; mi = 0; mj = 0;
    for (int r = 1; r <= n; r++) begin
      for (int c = 1; c <= m; c++) begin
        s = (rd_seq[r-1] == rf_seq[c-1]) ? MATCH : -MISMATCH;
        v = 0;
        if (h[r-1][c-1] + s > v) v = h[r-1][c-1] + s;
        if (h[r-1][c] - GAP > v) v = h[r-1][c] - GAP;
        if (h[r][c-1] - GAP > v) v = h[r][c-1] - GAP;
        if (v > SAT) v = SAT;
        h[r][c] = v;
        w.i = 8'(r); w.j = 8'(c); w.s = SW'(v);
        exp_q.push_back(w);
        if (v > mx) begin mx = v; mi = r; mj = c; end
      end
    end
  endtask

  // Starts a job, scoreboards writes each cycle, returns done cycle, busy and start counts.
  task automatic do_job(input int n, input int m, input int limit, input int glitch,
                        output int dc, output int bc, output int sc);
    wr_t e;
    @(negedge clk);
    read_len = LW'(n); ref_len = LW'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0; dc = 1; bc = 0; sc = 0;
    while (1) begin
      if (busy) bc++;
      if (mat_start) sc++;
      if (mat_op) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got (%0d,%0d)=%0d, required no write", mat_i, mat_j, mat_score);
        end else begin
          e = exp_q.pop_front();
          if ({mat_i, mat_j, mat_score} !== e) begin
            errors++;
            $display("FAIL write: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                     mat_i, mat_j, mat_score, e.i, e.j, e.s);
          end
        end
      end
      if (done || dc >= limit) break;
      if (dc == glitch) begin start = 1'b1; read_len = 1; ref_len = 1; end
      else start = 1'b0;
      @(negedge clk);
      dc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; read_len = '0; ref_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mat_start, mat_op} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 0000", {busy, done, mat_start, mat_op});
    end
    checks++;
    if ({mat_i, mat_j, read_idx, ref_idx, mat_score} !== '0) begin
      errors++; $display("FAIL reset_addr: got i=%0d j=%0d ri=%0d fi=%0d sc=%0d, required all 0",
                         mat_i, mat_j, read_idx, ref_idx, mat_score);
    end
    checks++;
    if ({max_score, max_i, max_j} !== '0) begin
      errors++; $display("FAIL reset_max: got %0d at (%0d,%0d), required 0 at (0,0)", max_score, max_i, max_j);
    end
`ifdef SW_CYCLE_CNT_EN
    checks++;
    if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d, required 0", cycles); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_ac_ac();
    int mx, mi, mj, dc, bc, sc;
    rd_seq[0] = 2'd0; rd_seq[1] = 2'd1; rf_seq[0] = 2'd0; rf_seq[1] = 2'd1;
    model_job(2, 2, mx, mi, mj);
    do_job(2, 2, 100, 0, dc, bc, sc);
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL ac_done_cycle: got %0d, required 22", dc); end
    checks++;
    if (bc !== 21 || sc !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ac_busy: got busy_cycles=%0d starts=%0d busy_at_done=%b, required 21 1 0", bc, sc, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ac_writes_left: got %0d, required 0", exp_q.size()); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if ({max_score, max_i, max_j} !== {4'd4, 8'd2, 8'd2} || done !== 1'b0) begin
      errors++; $display("FAIL ac_max: got %0d at (%0d,%0d) done=%b, required 4 at (2,2) done=0", max_score, max_i, max_j, done);
    end
  endtask

  task automatic test_invalid_len();
    int lens [4][2] = '{'{0, 3}, '{129, 1}, '{2, 0}, '{1, 129}};
    int dc, bc, sc;
    for (int k = 0; k < 4; k++) begin
      do_job(lens[k][0], lens[k][1], 10, 0, dc, bc, sc);
      checks++;
      if (dc !== 1 || bc !== 0 || sc !== 0) begin
        errors++; $display("FAIL invalid_%0d: got done_cycle=%0d busy=%0d starts=%0d, required 1 0 0", k, dc, bc, sc);
      end
      checks++;
      if ({max_score, max_i, max_j} !== '0) begin
        errors++; $display("FAIL invalid_max_%0d: got %0d at (%0d,%0d), required 0 at (0,0)", k, max_score, max_i, max_j);
      end
    end
  endtask

  task automatic test_mismatch();
    int mx, mi, mj, dc, bc, sc;
    rd_seq[0] = 2'd0; rf_seq[0] = 2'd2;
    model_job(1, 1, mx, mi, mj);
    do_job(1, 1, 50, 0, dc, bc, sc);
    checks++;
    if (dc !== 7) begin errors++; $display("FAIL mism_done_cycle: got %0d, required 7", dc); end
    checks++;
    if (exp_q.size() != 0 || {max_score, max_i, max_j} !== '0) begin
      errors++; $display("FAIL mism_max: got %0d at (%0d,%0d) left=%0d, required 0 at (0,0) left=0",
                         max_score, max_i, max_j, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_rect();
    int mx, mi, mj, dc, bc, sc;
    rd_seq[0] = 2'd2; rd_seq[1] = 2'd0; rd_seq[2] = 2'd3;
    rf_seq[0] = 2'd0; rf_seq[1] = 2'd3;
    model_job(3, 2, mx, mi, mj);
    do_job(3, 2, 100, 0, dc, bc, sc);
    checks++;
    if (dc !== 32 || bc !== 31) begin
      errors++; $display("FAIL rect_timing: got done=%0d busy=%0d, required 32 31", dc, bc);
    end
    checks++;
    if (exp_q.size() != 0 || max_score !== SW'(mx) || max_i !== LW'(mi) || max_j !== LW'(mj)) begin
      errors++; $display("FAIL rect_max: got %0d at (%0d,%0d), required %0d at (%0d,%0d)",
                         max_score, max_i, max_j, mx, mi, mj);
    end
    exp_q.delete();
  endtask

  task automatic test_saturate();
    int mx, mi, mj, dc, bc, sc;
    for (int k = 0; k < 8; k++) begin rd_seq[k] = 2'(k); rf_seq[k] = 2'(k); end
    model_job(8, 8, mx, mi, mj);
    do_job(8, 8, 400, 0, dc, bc, sc);
    checks++;
    if (dc !== 322) begin errors++; $display("FAIL sat_done_cycle: got %0d, required 322", dc); end
    checks++;
    if (exp_q.size() != 0 || {max_score, max_i, max_j} !== {4'd15, 8'd8, 8'd8}) begin
      errors++; $display("FAIL sat_max: got %0d at (%0d,%0d) left=%0d, required 15 at (8,8) left=0",
                         max_score, max_i, max_j, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_max_len();
    int mx, mi, mj, dc, bc, sc;
    for (int k = 0; k < 128; k++) rd_seq[k] = 2'($urandom_range(0, 3));
    rf_seq[0] = 2'd1;
    model_job(128, 1, mx, mi, mj);
    do_job(128, 1, 700, 0, dc, bc, sc);
    checks++;
    if (dc !== 642) begin errors++; $display("FAIL maxlen_done_cycle: got %0d, required 642", dc); end
    checks++;
    if (exp_q.size() != 0 || max_score !== SW'(mx) || max_i !== LW'(mi) || max_j !== LW'(mj)) begin
      errors++; $display("FAIL maxlen_max: got %0d at (%0d,%0d), required %0d at (%0d,%0d)",
                         max_score, max_i, max_j, mx, mi, mj);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_job();
    int mx, mi, mj, dc, bc, sc;
    rd_seq[0] = 2'd0; rd_seq[1] = 2'd1; rf_seq[0] = 2'd0; rf_seq[1] = 2'd1;
    model_job(2, 2, mx, mi, mj);
    do_job(2, 2, 13, 0, dc, bc, sc);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mat_start, mat_op, mat_i, mat_j, read_idx, ref_idx, mat_score} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b op=%b i=%0d j=%0d ri=%0d, required all 0",
                         busy, mat_op, mat_i, mat_j, read_idx);
    end
    checks++;
    if ({max_score, max_i, max_j} !== '0 || exp_q.size() != 2) begin
      errors++; $display("FAIL midrst_max: got %0d at (%0d,%0d) left=%0d, required 0 at (0,0) left=2",
                         max_score, max_i, max_j, exp_q.size());
    end
    exp_q.delete();
    rst_n = 1'b1;
    model_job(2, 2, mx, mi, mj);
    do_job(2, 2, 100, 0, dc, bc, sc);
    checks++;
    if (dc !== 22 || exp_q.size() != 0 || {max_score, max_i, max_j} !== {4'd4, 8'd2, 8'd2}) begin
      errors++; $display("FAIL midrst_rerun: got done=%0d max=%0d at (%0d,%0d), required 22 4 at (2,2)",
                         dc, max_score, max_i, max_j);
    end
    exp_q.delete();
  endtask

  task automatic test_start_while_busy();
    int mx, mi, mj, dc, bc, sc;
    rd_seq[0] = 2'd0; rd_seq[1] = 2'd1; rf_seq[0] = 2'd0; rf_seq[1] = 2'd1;
    model_job(2, 2, mx, mi, mj);
    do_job(2, 2, 100, 7, dc, bc, sc);
    checks++;
    if (dc !== 22 || bc !== 21 || sc !== 1) begin
      errors++; $display("FAIL busy_start_timing: got done=%0d busy=%0d starts=%0d, required 22 21 1", dc, bc, sc);
    end
    checks++;
    if (exp_q.size() != 0 || {max_score, max_i, max_j} !== {4'd4, 8'd2, 8'd2}) begin
      errors++; $display("FAIL busy_start_max: got %0d at (%0d,%0d), required 4 at (2,2)", max_score, max_i, max_j);
    end
`ifdef SW_CYCLE_CNT_EN
    checks++;
    if (cycles !== 32'd21) begin errors++; $display("FAIL busy_start_cycles: got %0d, required 21", cycles); end
`endif
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_ac_ac();
    test_invalid_len();
    test_mismatch();
    test_rect();
    test_saturate();
    test_max_len();
    test_reset_mid_job();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
